// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
// Shared definitions for the divider scheduler and related controllers.
//   DIV_AW / DIV_BW : dividend (and quotient) width / divisor (and remainder) width
//   DZ_QUOTIENT     : quotient reported for a divide-by-zero request
//   TAG_IDW         : requester-ID field width in a tag entry (covers up to 8 IDs)
//   tag_t           : one tag-pipe entry {v, id, dz, a_lo}
// -----------------------------------------------------------------------------
package div_pkg;

    localparam int          DIV_AW      = 8;
    localparam int          DIV_BW      = 5;
    localparam logic [7:0]  DZ_QUOTIENT = 8'hFF;
    localparam int          TAG_IDW     = 3;

    // a_lo keeps the low dividend bits so a divide-by-zero can report
    // the dividend as its remainder without involving the datapath.
    typedef struct packed {
        logic               v;
        logic [TAG_IDW-1:0] id;
        logic               dz;
        logic [DIV_BW-1:0]  a_lo;
    } tag_t;

endpackage

// File: rtl/rr_arb.sv
// -----------------------------------------------------------------------------
// rr_arb
// Round-robin priority pick: grants the first requester at or after ptr_i,
// wrapping modulo N. Purely combinational.
//   req_i     : request vector
//   ptr_i     : highest-priority index this cycle (must be < N)
//   gnt_o     : one-hot grant (zero when no request)
//   gnt_idx_o : index of the granted requester (0 when none)
//   gnt_any_o : a grant was issued
// -----------------------------------------------------------------------------
module rr_arb #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [PW-1:0] gnt_idx_o,
    output logic          gnt_any_o
);

    always_comb begin
        int  idx;
        logic found;
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        gnt_o     = '0;
        gnt_idx_o = '0;
        gnt_any_o = 1'b0;
        found     = 1'b0;
        for (int off = 0; off < N; off++) begin
            // Wrap by subtraction; ptr_i < N keeps idx below 2N.
            idx = int'(ptr_i) + off;
            if (idx >= N) idx = idx - N;
            if (!found && req_i[idx]) begin
                found      = 1'b1;
                gnt_o[idx] = 1'b1;
                gnt_idx_o  = PW'(idx);
                gnt_any_o  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/div_sched.sv
// -----------------------------------------------------------------------------
// div_sched
// Shares one external 8/5-bit divider among NREQ requesters. One request is
// accepted per cycle (round-robin), issued to the divider, and its requester
// ID is carried through a LAT-deep tag pipe so the result returns to the
// right per-requester response slot. Each requester has at most one
// operation in flight; divide-by-zero is answered locally.
//   clk, rst                   : clock, synchronous active-high reset
//   i_req_valid/a/b            : per-requester request handshake and operands
//   o_req_ready                : one-hot accept (combinational)
//   o_div_valid/a/b            : issue to the divider datapath
//   i_div_q/r                  : divider result, LAT cycles after issue
//   o_rsp_valid/q/r/dz         : per-requester result slot
//   i_rsp_ready                : per-requester result consume
// -----------------------------------------------------------------------------
module div_sched
    import div_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int LAT  = 1,
    parameter int IDW  = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          i_req_valid,
    input  logic [NREQ*DIV_AW-1:0]   i_req_a,
    input  logic [NREQ*DIV_BW-1:0]   i_req_b,
    output logic [NREQ-1:0]          o_req_ready,
    output logic [DIV_AW-1:0]        o_div_a,
    output logic [DIV_BW-1:0]        o_div_b,
    output logic                     o_div_valid,
    input  logic [DIV_AW-1:0]        i_div_q,
    input  logic [DIV_BW-1:0]        i_div_r,
    output logic [NREQ-1:0]          o_rsp_valid,
    output logic [NREQ*DIV_AW-1:0]   o_rsp_q,
    output logic [NREQ*DIV_BW-1:0]   o_rsp_r,
    output logic [NREQ-1:0]          o_rsp_dz,
    input  logic [NREQ-1:0]          i_rsp_ready
);

    logic [NREQ-1:0][DIV_AW-1:0] req_a_v;
    logic [NREQ-1:0][DIV_BW-1:0] req_b_v;

    logic [NREQ-1:0]             busy_q, busy_d;
    logic [IDW-1:0]              ptr_q, ptr_d;
    logic [NREQ-1:0]             rsp_valid_q, rsp_valid_d;
    logic [NREQ-1:0][DIV_AW-1:0] rsp_q_q, rsp_q_d;
    logic [NREQ-1:0][DIV_BW-1:0] rsp_r_q, rsp_r_d;
    logic [NREQ-1:0]             rsp_dz_q, rsp_dz_d;
    tag_t                        tag_q [LAT];
    tag_t                        new_tag;
    tag_t                        tail;

    logic [NREQ-1:0]             eligible;
    logic [IDW-1:0]              win_idx;
    logic                        win_any;

    assign req_a_v = i_req_a;
    assign req_b_v = i_req_b;

    // busy is registered, so a consume this cycle cannot re-grant the same
    // requester until the next cycle (and i_rsp_ready never reaches o_req_ready).
    assign eligible = i_req_valid & ~busy_q;

    rr_arb #(
        .N  (NREQ),
        .PW (IDW)
    ) u_arb (
        .req_i     (eligible),
        .ptr_i     (ptr_q),
        .gnt_o     (o_req_ready),
        .gnt_idx_o (win_idx),
        .gnt_any_o (win_any)
    );

    // Issue: a grant is always a transfer because eligibility includes valid.
    assign o_div_valid = win_any;
    assign o_div_a     = win_any ? req_a_v[win_idx] : '0;
    assign o_div_b     = win_any ? req_b_v[win_idx] : '0;

    always_comb begin
        new_tag      = '0;
        new_tag.v    = win_any;
        new_tag.id   = TAG_IDW'(win_idx);
        new_tag.dz   = win_any && (o_div_b == '0);
        new_tag.a_lo = o_div_a[DIV_BW-1:0];
    end

    assign tail = tag_q[LAT-1];

    always_comb begin
        busy_d      = (busy_q & ~(rsp_valid_q & i_rsp_ready)) | o_req_ready;
        ptr_d       = ptr_q;
        if (win_any) begin
            ptr_d = (win_idx == IDW'(NREQ - 1)) ? '0 : win_idx + IDW'(1);
        end
        rsp_valid_d = rsp_valid_q & ~i_rsp_ready;
        rsp_q_d     = rsp_q_q;
        rsp_r_d     = rsp_r_q;
        rsp_dz_d    = rsp_dz_q;
        // Busy guarantees the target slot is empty (or consumed this cycle).
        for (int k = 0; k < NREQ; k++) begin
            if (tail.v && (tail.id == TAG_IDW'(k))) begin
                rsp_valid_d[k] = 1'b1;
                rsp_q_d[k]     = tail.dz ? DZ_QUOTIENT : i_div_q;
                rsp_r_d[k]     = tail.dz ? tail.a_lo   : i_div_r;
                rsp_dz_d[k]    = tail.dz;
            end
        end
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q      <= '0;
            ptr_q       <= '0;
            rsp_valid_q <= '0;
            // NOTE: result data is cleared too, so the outputs are defined right after reset.
            rsp_q_q     <= '0;
            rsp_r_q     <= '0;
            rsp_dz_q    <= '0;
            for (int i = 0; i < LAT; i++) tag_q[i] <= '0;
        end else begin
            busy_q      <= busy_d;
            ptr_q       <= ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_q_q     <= rsp_q_d;
            rsp_r_q     <= rsp_r_d;
            rsp_dz_q    <= rsp_dz_d;
            tag_q[0]    <= new_tag;
            for (int i = 1; i < LAT; i++) tag_q[i] <= tag_q[i-1];
        end
    end

    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_q     = rsp_q_q;
    assign o_rsp_r     = rsp_r_q;
    assign o_rsp_dz    = rsp_dz_q;

endmodule

// File: tb/tb_div_sched.sv
// -----------------------------------------------------------------------------
// tb_div_sched
// Drives two schedulers (LAT=1 and LAT=3) with identical request/consume
// stimulus. Each has a behavioural divider attached and is compared every
// cycle against a reference model built from the scheduling rules: RR pick
// from a pointer, one outstanding op per requester, result due LAT+1 cycles
// after accept, held until consumed.
// -----------------------------------------------------------------------------
module tb_div_sched;

    localparam int NREQ = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [NREQ-1:0]   req_valid;
    logic [NREQ*8-1:0] req_a;
    logic [NREQ*5-1:0] req_b;
    logic [NREQ-1:0]   rsp_ready;

    logic [NREQ-1:0]   req_ready [2];
    logic [7:0]        div_a     [2];
    logic [4:0]        div_b     [2];
    logic              div_valid [2];
    logic [7:0]        div_q     [2];
    logic [4:0]        div_r     [2];
    logic [NREQ-1:0]   rsp_valid [2];
    logic [NREQ*8-1:0] rsp_q     [2];
    logic [NREQ*5-1:0] rsp_r     [2];
    logic [NREQ-1:0]   rsp_dz    [2];

    div_sched #(.NREQ(NREQ), .LAT(1), .IDW(2)) dut_l1 (
        .clk(clk), .rst(rst),
        .i_req_valid(req_valid), .i_req_a(req_a), .i_req_b(req_b),
        .o_req_ready(req_ready[0]),
        .o_div_a(div_a[0]), .o_div_b(div_b[0]), .o_div_valid(div_valid[0]),
        .i_div_q(div_q[0]), .i_div_r(div_r[0]),
        .o_rsp_valid(rsp_valid[0]), .o_rsp_q(rsp_q[0]), .o_rsp_r(rsp_r[0]),
        .o_rsp_dz(rsp_dz[0]), .i_rsp_ready(rsp_ready)
    );

    div_sched #(.NREQ(NREQ), .LAT(3), .IDW(2)) dut_l3 (
        .clk(clk), .rst(rst),
        .i_req_valid(req_valid), .i_req_a(req_a), .i_req_b(req_b),
        .o_req_ready(req_ready[1]),
        .o_div_a(div_a[1]), .o_div_b(div_b[1]), .o_div_valid(div_valid[1]),
        .i_div_q(div_q[1]), .i_div_r(div_r[1]),
        .o_rsp_valid(rsp_valid[1]), .o_rsp_q(rsp_q[1]), .o_rsp_r(rsp_r[1]),
        .o_rsp_dz(rsp_dz[1]), .i_rsp_ready(rsp_ready)
    );

    // Behavioural divider; a zero divisor yields junk the scheduler must ignore.
    function automatic logic [12:0] dp_fn(input logic [7:0] a, input logic [4:0] b);
        if (b == 5'd0) return {8'hAA, 5'h15};
        return {8'(a / b), 5'(a % b)};
    endfunction

    logic [12:0] dp1;
    logic [12:0] dp3 [3];
    always @(posedge clk) begin
        dp1    <= dp_fn(div_a[0], div_b[0]);
        dp3[0] <= dp_fn(div_a[1], div_b[1]);
        dp3[1] <= dp3[0];
        dp3[2] <= dp3[1];
    end
    assign div_q[0] = dp1[12:5];
    assign div_r[0] = dp1[4:0];
    assign div_q[1] = dp3[2][12:5];
    assign div_r[1] = dp3[2][4:0];

    // ---------------- reference model ----------------
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   m_ptr  [2];
    bit   m_busy [2][NREQ];
    bit   m_pend [2][NREQ];
    int   m_due  [2][NREQ];
    logic [7:0] m_q [2][NREQ];
    logic [4:0] m_r [2][NREQ];
    bit   m_dz   [2][NREQ];
    bit   m_vis  [2][NREQ];
    int   e_win  [2];
    logic [NREQ*8-1:0] c_a;
    logic [NREQ*5-1:0] c_b;
    logic [NREQ-1:0]   c_rr;

    function automatic int lat_of(input int n);
        return (n == 0) ? 1 : 3;
    endfunction

    task automatic check(input string tag, input int n, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s (LAT=%0d) cycle %0d: observed %0h expected %0h", tag, lat_of(n), cyc, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int n = 0; n < 2; n++) begin
            m_ptr[n] = 0;
            for (int k = 0; k < NREQ; k++) begin
                m_busy[n][k] = 1'b0;
                m_pend[n][k] = 1'b0;
                m_vis[n][k]  = 1'b0;
            end
        end
    endtask

    task automatic check_comb();
        for (int n = 0; n < 2; n++) begin
            int         w;
            logic [3:0] er;
            bit         ev;
            w = -1;
            for (int off = 0; off < NREQ; off++) begin
                int k;
                k = (m_ptr[n] + off) % NREQ;
                if (w < 0 && req_valid[k] && !m_busy[n][k]) w = k;
            end
            er = '0;
            if (w >= 0) er[w] = 1'b1;
            e_win[n] = w;
            check("req_ready", n, 32'(req_ready[n]), 32'(er));
            check("div_valid", n, 32'(div_valid[n]), 32'(er != 4'd0));
            if (w >= 0) begin
                check("div_a", n, 32'(div_a[n]), 32'(req_a[8*w +: 8]));
                check("div_b", n, 32'(div_b[n]), 32'(req_b[5*w +: 5]));
            end else begin
                check("div_a_idle", n, 32'(div_a[n]), 32'd0);
                check("div_b_idle", n, 32'(div_b[n]), 32'd0);
            end
            for (int k = 0; k < NREQ; k++) begin
                ev = m_pend[n][k] && (cyc >= m_due[n][k]);
                m_vis[n][k] = ev;
                check($sformatf("rsp_valid[%0d]", k), n, 32'(rsp_valid[n][k]), 32'(ev));
                if (ev) begin
                    check($sformatf("rsp_q[%0d]", k),  n, 32'(rsp_q[n][8*k +: 8]), 32'(m_q[n][k]));
                    check($sformatf("rsp_r[%0d]", k),  n, 32'(rsp_r[n][5*k +: 5]), 32'(m_r[n][k]));
                    check($sformatf("rsp_dz[%0d]", k), n, 32'(rsp_dz[n][k]),       32'(m_dz[n][k]));
                end
            end
        end
        c_a  = req_a;
        c_b  = req_b;
        c_rr = rsp_ready;
    endtask

    task automatic model_update();
        if (rst) begin
            clear_model();
        end else begin
            for (int n = 0; n < 2; n++) begin
                for (int k = 0; k < NREQ; k++) begin
                    if (m_vis[n][k] && c_rr[k]) begin
                        m_pend[n][k] = 1'b0;
                        m_busy[n][k] = 1'b0;
                    end
                end
                if (e_win[n] >= 0) begin
                    int         w;
                    logic [7:0] a;
                    logic [4:0] b;
                    w = e_win[n];
                    a = c_a[8*w +: 8];
                    b = c_b[5*w +: 5];
                    m_busy[n][w] = 1'b1;
                    m_pend[n][w] = 1'b1;
                    m_due[n][w]  = cyc + 1 + lat_of(n);
                    if (b == 5'd0) begin
                        m_q[n][w]  = 8'hFF;
                        m_r[n][w]  = a[4:0];
                        m_dz[n][w] = 1'b1;
                    end else begin
                        m_q[n][w]  = 8'(a / b);
                        m_r[n][w]  = 5'(a % b);
                        m_dz[n][w] = 1'b0;
                    end
                    m_ptr[n] = (w + 1) % NREQ;
                end
            end
        end
        cyc++;
    endtask

    // One clock cycle: check mid-cycle, advance model at the edge, return 1 time unit later.
    task automatic cycle();
        @(negedge clk);
        check_comb();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cycle();
    endtask

    task automatic set_req(input int k, input logic [7:0] a, input logic [4:0] b);
        req_valid[k]    = 1'b1;
        req_a[8*k +: 8] = a;
        req_b[5*k +: 5] = b;
    endtask

    task automatic clr_req(input int k);
        req_valid[k] = 1'b0;
    endtask

    task automatic rand_others(input int skip);
        for (int k = 0; k < NREQ; k++) begin
            if (k != skip) begin
                req_valid[k]    = ($urandom_range(0, 1) == 1);
                req_a[8*k +: 8] = 8'($urandom);
                req_b[5*k +: 5] = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            end
        end
    endtask

    initial begin
        logic [3:0] exp_gnt;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = '1;
        rst       = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        clear_model();

        // Reset state
        for (int n = 0; n < 2; n++) begin
            check("reset_rsp_valid", n, 32'(rsp_valid[n]), 32'd0);
            check("reset_req_ready", n, 32'(req_ready[n]), 32'd0);
            check("reset_div_valid", n, 32'(div_valid[n]), 32'd0);
        end
        idle(2);

        // Single request: 200 / 7
        set_req(0, 8'd200, 5'd7);
        cycle();
        clr_req(0);
        cycle();
        check("t1_valid", 0, 32'(rsp_valid[0][0]), 32'd1);
        check("t1_q",     0, 32'(rsp_q[0][7:0]),   32'd28);
        check("t1_r",     0, 32'(rsp_r[0][4:0]),   32'd4);
        check("t1_dz",    0, 32'(rsp_dz[0][0]),    32'd0);
        idle(4);

        // Divide by zero: 13 / 0
        set_req(1, 8'd13, 5'd0);
        cycle();
        clr_req(1);
        cycle();
        check("dz_valid", 0, 32'(rsp_valid[0][1]), 32'd1);
        check("dz_q",     0, 32'(rsp_q[0][15:8]),  32'hFF);
        check("dz_r",     0, 32'(rsp_r[0][9:5]),   32'd13);
        check("dz_flag",  0, 32'(rsp_dz[0][1]),    32'd1);
        idle(4);

        // All four valid from reset
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        set_req(0, 8'd255, 5'd31);
        set_req(1, 8'd100, 5'd3);
        set_req(2, 8'd7,   5'd9);
        set_req(3, 8'd64,  5'd8);
        for (int i = 0; i < NREQ; i++) begin
            #1;
            exp_gnt = 4'b0001 << i;
            check("rr_order", 0, 32'(req_ready[0]), 32'(exp_gnt));
            cycle();
        end
        req_valid = '0;
        check("all4_q2", 0, 32'(rsp_q[0][23:16]), 32'd0);
        check("all4_r2", 0, 32'(rsp_r[0][14:10]), 32'd7);
        cycle();
        check("all4_q3", 0, 32'(rsp_q[0][31:24]), 32'd8);
        check("all4_r3", 0, 32'(rsp_r[0][19:15]), 32'd0);
        idle(6);

        // Backpressure on requester 2 while others keep running
        rsp_ready[2] = 1'b0;
        set_req(2, 8'd90, 5'd11);
        repeat (6) begin
            rand_others(2);
            cycle();
        end
        repeat (5) begin
            check("bp_valid", 0, 32'(rsp_valid[0][2]), 32'd1);
            check("bp_q",     0, 32'(rsp_q[0][23:16]), 32'd8);
            check("bp_r",     0, 32'(rsp_r[0][14:10]), 32'd2);
            rand_others(2);
            cycle();
        end
        req_valid    = 4'b0100;
        rsp_ready[2] = 1'b1;
        cycle();
        check("bp_regrant", 0, 32'(req_ready[0]), 32'b0100);
        cycle();
        req_valid = '0;
        idle(6);

        // Reset while requester 3 is in flight
        set_req(3, 8'd77, 5'd5);
        cycle();
        clr_req(3);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        repeat (5) begin
            check("rst_no_stale_l1", 0, 32'(rsp_valid[0]), 32'd0);
            check("rst_no_stale_l3", 1, 32'(rsp_valid[1]), 32'd0);
            cycle();
        end
        set_req(3, 8'd9,  5'd2);
        set_req(0, 8'd50, 5'd6);
        #1;
        check("rst_ptr_zero", 0, 32'(req_ready[0]), 32'b0001);
        cycle();
        req_valid = '0;
        idle(6);

        // Randomized traffic with random backpressure
        repeat (600) begin
            rand_others(-1);
            for (int k = 0; k < NREQ; k++) rsp_ready[k] = ($urandom_range(0, 3) != 0);
            cycle();
        end
        req_valid = '0;
        rsp_ready = '1;
        idle(8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
